// File: rtl/approx_mul_seq_ctrl.sv
// Sequencing controller for an external 8x8 approximate-multiplier half-adder array.
// Latches operands, then sums the array rows one per cycle into a saturated product.
module approx_mul_seq_ctrl #(
  parameter int W         = 8,
  parameter int NUM_ROWS  = 4,
  parameter int ROW_SHIFT = 2,
  parameter int ACC_W     = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_x,
  input  logic [W-1:0]          in_y,
  output logic [W-1:0]          arr_x,
  output logic [W-1:0]          arr_y,
  input  logic [NUM_ROWS*7-1:0] arr_b,
  input  logic [NUM_ROWS*9-1:0] arr_t,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*W-1:0]        out_product,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  // b bits sit two columns above t bits within a row
  localparam int B_OFS = 2;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ROW_W-1:0]   r_row;
  logic [ACC_W-1:0]   r_acc;
  logic [W-1:0]       r_arr_x;
  logic [W-1:0]       r_arr_y;
  logic [2*W-1:0]     r_product;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last_row;
  logic [6:0]         w_b_rows [NUM_ROWS];
  logic [8:0]         w_t_rows [NUM_ROWS];
  logic [ACC_W-1:0]   w_row_base;
  logic [ACC_W-1:0]   w_row_val;
  logic [ACC_W-1:0]   w_acc_sum;

  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_rows
    assign w_b_rows[gi] = arr_b[7*gi +: 7];
    assign w_t_rows[gi] = arr_t[9*gi +: 9];
  end

  assign w_row_base = ACC_W'(w_t_rows[r_row]) + (ACC_W'(w_b_rows[r_row]) << B_OFS);
  assign w_row_val  = w_row_base << (ROW_SHIFT * r_row);
  assign w_acc_sum  = r_acc + w_row_val;
  assign w_last_row = (r_row == ROW_W'(NUM_ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_ACC;
        end
      end
      S_ACC: begin
        if (w_last_row) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row     <= '0;
      r_acc     <= '0;
      r_arr_x   <= '0;
      r_arr_y   <= '0;
      r_product <= '0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_arr_x <= in_x;
      r_arr_y <= in_y;
      r_acc   <= '0;
      r_row   <= '0;
    end else if (r_state == S_ACC) begin
      r_acc <= w_acc_sum;
      r_row <= r_row + ROW_W'(1);
      // Product is captured with the final row so it is already stable in DONE
      if (w_last_row) begin
        r_product <= w_acc_sum[ACC_W-1] ? '1 : w_acc_sum[2*W-1:0];
        r_ovf     <= w_acc_sum[ACC_W-1];
      end
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign arr_x       = r_arr_x;
  assign arr_y       = r_arr_y;
  assign out_product = r_product;
  assign out_ovf     = r_ovf;

endmodule

// File: tb/tb_approx_mul_seq_ctrl.sv
// Self-checking bench: models the external approximate array and a row-sum golden reference.
module tb_approx_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x, in_y;
  logic [7:0]  arr_x, arr_y;
  logic [27:0] arr_b;
  logic [35:0] arr_t;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic        out_ovf;
  logic        busy;

  logic        raw_mode;
  logic [27:0] raw_b;
  logic [35:0] raw_t;

  int n_vec = 0;
  int n_err = 0;

  approx_mul_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .arr_x(arr_x), .arr_y(arr_y), .arr_b(arr_b), .arr_t(arr_t),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Row k combines partial products of x bits 2k and 2k+1; column 1 is carry-only.
  function automatic logic [6:0] model_b(input logic [7:0] x, input logic [7:0] y, input int k);
    logic [7:0] p0, p1;
    logic [6:0] b;
    p0 = x[2*k]   ? y : 8'h00;
    p1 = x[2*k+1] ? y : 8'h00;
    b[0] = p0[1] | p1[0];
    for (int j = 2; j < 8; j++) b[j-1] = p0[j] & p1[j-1];
    return b;
  endfunction

  function automatic logic [8:0] model_t(input logic [7:0] x, input logic [7:0] y, input int k);
    logic [7:0] p0, p1;
    logic [8:0] t;
    p0 = x[2*k]   ? y : 8'h00;
    p1 = x[2*k+1] ? y : 8'h00;
    t[0] = p0[0];
    t[1] = 1'b0;
    for (int j = 2; j < 8; j++) t[j] = p0[j] ^ p1[j-1];
    t[8] = p1[7];
    return t;
  endfunction

  function automatic logic [27:0] pack_b(input logic [7:0] x, input logic [7:0] y);
    logic [27:0] v;
    for (int k = 0; k < 4; k++) v[7*k +: 7] = model_b(x, y, k);
    return v;
  endfunction

  function automatic logic [35:0] pack_t(input logic [7:0] x, input logic [7:0] y);
    logic [35:0] v;
    for (int k = 0; k < 4; k++) v[9*k +: 9] = model_t(x, y, k);
    return v;
  endfunction

  // Returns {ovf, product}: weighted sum of all row bits, saturated to 16 bits.
  function automatic logic [16:0] golden(input logic [27:0] bv, input logic [35:0] tv);
    int unsigned acc;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 9; j++) if (tv[9*k+j]) acc += (32'd1 << (2*k + j));
      for (int j = 0; j < 7; j++) if (bv[7*k+j]) acc += (32'd1 << (2*k + j + 2));
    end
    if (acc > 32'd65535) return {1'b1, 16'hFFFF};
    return {1'b0, acc[15:0]};
  endfunction

  always_comb begin
    arr_b = raw_b;
    arr_t = raw_t;
    if (!raw_mode) begin
      arr_b = pack_b(arr_x, arr_y);
      arr_t = pack_t(arr_x, arr_y);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge with the controller idle.
  task automatic run_txn(input logic [7:0] x, input logic [7:0] y, input int stall);
    logic [16:0] exp_v;
    int cyc;
    exp_v = raw_mode ? golden(raw_b, raw_t) : golden(pack_b(x, y), pack_t(x, y));
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_x      = x;
    in_y      = y;
    out_ready = (stall == 0);
    @(negedge clk);
    cyc = 1;
    in_valid = 1'b0;
    check("arr_x", 32'(arr_x), 32'(x));
    check("arr_y", 32'(arr_y), 32'(y));
    check("busy_acc", 32'(busy), 32'd1);
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'd5);
    check("product", 32'(out_product), 32'(exp_v[15:0]));
    check("ovf", 32'(out_ovf), 32'(exp_v[16]));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_x     = 8'($urandom);
      in_y     = 8'($urandom);
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_product", 32'(out_product), 32'(exp_v[15:0]));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_arr_x", 32'(arr_x), 32'(x));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic seen_valid;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b1;
    raw_mode  = 1'b0;
    raw_b     = '0;
    raw_t     = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product", 32'(out_product), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_arr_x", 32'(arr_x), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(8'h01, 8'h01, 0);
    check("dir_1x1", 32'(out_product), 32'h0001);
    run_txn(8'h01, 8'h02, 0);
    check("dir_1x2", 32'(out_product), 32'h0004);
    run_txn(8'h04, 8'h01, 0);
    check("dir_4x1", 32'(out_product), 32'h0004);
    run_txn(8'hFF, 8'hFF, 0);
    run_txn(8'hA5, 8'h3C, 10);

    raw_mode = 1'b1;
    raw_b    = '1;
    raw_t    = '1;
    run_txn(8'h00, 8'h00, 0);
    check("sat_product", 32'(out_product), 32'hFFFF);
    check("sat_ovf", 32'(out_ovf), 32'd1);
    raw_mode = 1'b0;

    // Reset while row 2 is being accumulated
    in_valid = 1'b1;
    in_x     = 8'h37;
    in_y     = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_product", 32'(out_product), 32'd0);
    check("mid_rst_ovf", 32'(out_ovf), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_arr_y", 32'(arr_y), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("no_valid_after_rst", 32'(seen_valid), 32'd0);
    run_txn(8'h12, 8'h34, 0);

    for (int n = 0; n < 2000; n++) begin
      raw_mode = ($urandom_range(0, 7) == 0);
      raw_b    = 28'($urandom);
      raw_t    = {4'($urandom), 32'($urandom)};
      run_txn(8'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    raw_mode = 1'b0;
    run_txn(8'hFF, 8'hFF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/approx_mul_seq_ctrl.md
Name: approx_mul_seq_ctrl

Overview:
- Sequencing controller for the 8x8 unsigned approximate-multiplier half-adder array stage.
- Accepts operand pairs over a valid/ready handshake, drives the registered operands onto the array, then reduces the four array rows into a 16-bit product.
- Reduction uses one shared adder, one row per clock.
- Sits between the operand source and the product consumer; the array itself is external and purely combinational.

Parameters:
- W, 8, operand width (x and y).
- NUM_ROWS, 4, number of array rows (W/2); one row is accumulated per cycle.
- ROW_SHIFT, 2, weight step between consecutive rows (row k base weight 2^(ROW_SHIFT*k)).
- ACC_W, 17, accumulator width; one guard bit above the 2W-bit product.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands.
- in_x  in  W  multiplicand.
- in_y  in  W  multiplier.
- arr_x  out  W  registered x driven to the array.
- arr_y  out  W  registered y driven to the array.
- arr_b  in  NUM_ROWS*7  array b outputs; row k occupies bits [7k+6:7k].
- arr_t  in  NUM_ROWS*9  array t outputs; row k occupies bits [9k+8:9k].
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_product  out  2W  saturated approximate product.
- out_ovf  out  1  accumulator exceeded 2^(2W)-1 for this product.
- busy  out  1  high in ACC or DONE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, row counter=0, acc=0, arr_x=arr_y=0.
  - in_ready=1, out_valid=0, out_product=0, out_ovf=0, busy=0.
- States: IDLE, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_x/in_y into arr_x/arr_y, clear acc, row=0, go to ACC.
- ACC:
  - in_ready=0.
  - Each cycle: acc <= acc + rowval(row), where rowval(k) = sum_j t_k[j]*2^(2k+j) + sum_j b_k[j]*2^(2k+j+2) (j over 0..8 for t, 0..6 for b).
  - row increments each cycle. After row NUM_ROWS-1 is added, go to DONE.
- DONE:
  - out_valid=1.
  - out_product = acc[ACC_W-1] ? all-ones : acc[2W-1:0].
  - out_ovf = acc[ACC_W-1].
  - out_product and out_ovf are registered and held stable while out_valid&!out_ready.
  - On out_ready: go to IDLE; out_valid drops next cycle.
- Latency and throughput:
  - Accept at edge E0; out_valid rises after edge E0+NUM_ROWS (4 cycles).
  - Throughput: one product per NUM_ROWS+2 cycles with out_ready held high.
  - No overlap: in_ready is low from accept until the cycle after the DONE handshake.
- arr_x/arr_y change only on accept. They are stable through ACC and DONE, so the array outputs are stable while rows are read.
- in_valid in ACC/DONE: ignored, not latched. The source holds operands per handshake rules.
- out_product/out_ovf keep the last value after leaving DONE; out_valid qualifies them.
- Reset asserted mid-ACC or mid-DONE: immediate return to reset values. The partial accumulation and pending product are discarded, with no out_valid pulse.
- The array is approximate: results may exceed or fall below x*y. The controller sums exactly what the array presents and performs no correction.

Test Plan:
- Reset, then x=0x01, y=0x01 with out_ready=1 -> out_valid 4 cycles after accept, out_product=0x0001, out_ovf=0, in_ready back high 2 cycles later.
- x=0x01, y=0x02 -> out_product=0x0004 (the array's carry-only column 1 doubles the term). Check that the weight 2^(2k+j+2) is applied to b bits.
- x=0x04, y=0x01 -> out_product=0x0004 (row 1 t[0]). Check the row-1 shift of 2.
- Hold out_ready=0 for 10 cycles in DONE with in_valid=1 and changing in_x -> out_product stable, in_ready=0, no new operand latched; one product emitted on release.
- Random sweep of 2000 operand pairs plus all-ones x=y=0xFF, compared against a golden model of the array row sum with saturation -> exact match on out_product/out_ovf, no dropped or duplicated transactions.
- Assert rst_n low during ACC row 2 -> all outputs at reset values immediately; no out_valid pulse after release; the next transaction produces a correct result.
